// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device clock falls (odd parity, stop) and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_DATA,
        S_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] dat_sync_reg;
    logic                   clk_prev_reg;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    logic [7:0]       byte_reg, byte_next;
    logic             parity_reg, parity_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic             drive_reg, drive_next;
    logic [INH_W-1:0] inh_cnt_reg, inh_cnt_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic             tmo_active;

    // Idle PS/2 lines float high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_reg <= '1;
            dat_sync_reg <= '1;
            clk_prev_reg <= 1'b1;
        end else begin
            clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clock_in};
            dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev_reg <= clk_sync_reg[SYNC_STAGES-1];
        end
    end

    assign clk_s = clk_sync_reg[SYNC_STAGES-1];
    assign dat_s = dat_sync_reg[SYNC_STAGES-1];
    assign fall  = clk_prev_reg & ~clk_s;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            byte_reg    <= '0;
            parity_reg  <= 1'b0;
            bit_cnt_reg <= '0;
            drive_reg   <= 1'b0;
            inh_cnt_reg <= '0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            byte_reg    <= byte_next;
            parity_reg  <= parity_next;
            bit_cnt_reg <= bit_cnt_next;
            drive_reg   <= drive_next;
            inh_cnt_reg <= inh_cnt_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        byte_next    = byte_reg;
        parity_next  = parity_reg;
        bit_cnt_next = bit_cnt_reg;
        drive_next   = drive_reg;
        inh_cnt_next = inh_cnt_reg;
        tmo_cnt_next = tmo_cnt_reg;
        tmo_active   = 1'b0;
        tx_ready     = 1'b0;
        tx_done      = 1'b0;
        tx_error     = 1'b0;
        rx_inhibit   = 1'b1;
        ps2_clock_oe = 1'b0;
        ps2_data_oe  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                tx_ready   = 1'b1;
                rx_inhibit = 1'b0;
                if (tx_valid) begin
                    byte_next    = tx_data;
                    parity_next  = ~^tx_data;
                    inh_cnt_next = '0;
                    state_next   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                ps2_clock_oe = 1'b1;
                if (inh_cnt_reg == INH_LAST) begin
                    tmo_cnt_next = '0;
                    state_next   = S_RTS;
                end else begin
                    inh_cnt_next = inh_cnt_reg + 1'b1;
                end
            end
            S_RTS: begin
                // Data held low acts as the start bit; the first fall loads bit 0.
                ps2_data_oe = 1'b1;
                tmo_active  = 1'b1;
                if (fall) begin
                    bit_cnt_next = 4'd1;
                    drive_next   = ~byte_reg[0];
                    state_next   = S_DATA;
                end
            end
            S_DATA: begin
                ps2_data_oe = drive_reg;
                tmo_active  = 1'b1;
                if (fall) begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg < 4'd8) begin
                        drive_next = ~byte_reg[bit_cnt_reg[2:0]];
                    end else if (bit_cnt_reg == 4'd8) begin
                        drive_next = ~parity_reg;
                    end else begin
                        drive_next = 1'b0;
                        state_next = S_ACK;
                    end
                end
            end
            S_ACK: begin
                tmo_active = 1'b1;
                if (fall) begin
                    state_next = dat_s ? S_ERROR : S_DONE;
                end
            end
            S_DONE: begin
                tmo_active = 1'b1;
                if (clk_s && dat_s) begin
                    tx_done    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_ERROR: begin
                tx_error   = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // A fall restarts the watchdog; a completing DONE wins over a same-cycle expiry.
        if (tmo_active) begin
            if (fall) begin
                tmo_cnt_next = '0;
            end else if (tmo_cnt_reg == TMO_LIMIT) begin
                if (!tx_done) begin
                    state_next = S_ERROR;
                end
            end else begin
                tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
        end
    end

endmodule
